// File: rtl/i2c_rx_capture.sv
// Passive I2C read-byte capture: synchronises scl/sda, deserialises MSB-first bytes into a small FIFO
// and presents them over valid/ready. Optional scl-stall timeout is enabled by defining I2C_RX_TIMEOUT_EN.
module i2c_rx_capture #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_in,
    input  logic       listen,
    input  logic       data_ready,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic [7:0] byte_count,
    output logic       overrun,
    output logic       timeout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {IDLE, BITS, ACK} state_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("i2c_rx_capture: DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 2");
    end

    logic       scl_m, scl_s, scl_d;
    logic       sda_m, sda_s, sda_d;
    logic       scl_rise, scl_edge, start_det, stop_det;
    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       push, pop, full;
    logic [7:0] push_byte;
    logic       arm_ok, tmo_trip;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    mem [DEPTH];

    // Two-flop synchronisers plus one history flop for edge detection; preset to idle-bus level
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_m <= 1'b1; scl_s <= 1'b1; scl_d <= 1'b1;
            sda_m <= 1'b1; sda_s <= 1'b1; sda_d <= 1'b1;
        end else begin
            scl_m <= scl;    scl_s <= scl_m;  scl_d <= scl_s;
            sda_m <= sda_in; sda_s <= sda_m;  sda_d <= sda_s;
        end
    end

    assign scl_rise  = scl_s & ~scl_d;
    assign scl_edge  = scl_s ^ scl_d;
    assign start_det = scl_s & sda_d & ~sda_s;
    assign stop_det  = scl_s & ~sda_d & sda_s;

    assign push_byte = {shift[6:0], sda_s};
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign data_valid = (wr_ptr != rd_ptr);
    assign data_out   = mem[rd_ptr[AW-1:0]];
    assign pop        = data_valid & data_ready;

    // Completed byte: 8th rise in BITS, not pre-empted by listen drop or START/STOP
    always_comb begin
        push = 1'b0;
        if (state == BITS && listen && !start_det && !stop_det && !tmo_trip
            && scl_rise && bit_cnt == 3'd7) begin
            push = 1'b1;
        end
    end

`ifdef I2C_RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt;
    logic          rearm_block;

    assign tmo_trip = (state != IDLE) && listen && !start_det && !stop_det && !scl_edge
                      && (tmo_cnt >= TW'(TIMEOUT_CYC - 1));
    assign arm_ok   = ~rearm_block;

    // Stall counter; after a trip the block stays idle until listen is seen low
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt     <= '0;
            timeout     <= 1'b0;
            rearm_block <= 1'b0;
        end else begin
            if (state == IDLE || scl_edge || start_det || stop_det) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (tmo_trip) begin
                timeout     <= 1'b1;
                rearm_block <= 1'b1;
            end else if (!listen) begin
                rearm_block <= 1'b0;
            end
        end
    end
`else
    assign tmo_trip = 1'b0;
    assign arm_ok   = 1'b1;
    assign timeout  = 1'b0;
`endif

    // Receive FSM: abort conditions first, then bit shifting on scl rise
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            shift   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (listen && arm_ok) begin
                        state   <= BITS;
                        bit_cnt <= 3'd0;
                    end
                end
                default: begin
                    if (!listen || stop_det || tmo_trip) begin
                        state   <= IDLE;
                        bit_cnt <= 3'd0;
                        shift   <= 8'd0;
                    end else if (start_det) begin
                        state   <= BITS;
                        bit_cnt <= 3'd0;
                        shift   <= 8'd0;
                    end else if (scl_rise) begin
                        if (state == BITS) begin
                            shift   <= push_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= ACK;
                            end
                        end else begin
                            state   <= BITS;
                            bit_cnt <= 3'd0;
                        end
                    end
                end
            endcase
        end
    end

    // FIFO storage; a push while full is dropped unless a pop frees the head slot in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            byte_count <= 8'd0;
            overrun    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'd0;
            end
        end else begin
            if (push) begin
                byte_count <= byte_count + 8'd1;
                if (!full || pop) begin
                    mem[wr_ptr[AW-1:0]] <= push_byte;
                    wr_ptr              <= wr_ptr + PW'(1);
                end else begin
                    overrun <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule
